// File: rtl/uart_pkg.sv
// Line format shared by the UART receiver and transmitter: 8N1, LSB first,
// 16x oversampling.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 7;
  localparam int unsigned DATA_BITS  = 8;

endpackage

// File: rtl/baud_tick_gen.sv
// Free-running divider producing a one-clock oversample tick every CLK_DIV
// clocks.
module baud_tick_gen #(
  parameter int unsigned CLK_DIV = 163
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a one-entry output register and
// sticky overrun / framing-error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = 163
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       RxD,
  input  logic       read,
  output logic [7:0] data,
  output logic       valid,
  output logic       overrun,
  output logic       frame_error,
  output logic       busy
);

  localparam logic [3:0] S_MID  = 4'(MID_SAMPLE);
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [2:0] N_LAST = 3'(DATA_BITS - 1);

  logic        tick;
  logic        sync1_q, sync2_q;
  logic        rx;
  uart_state_e state_q, state_d;
  logic [3:0]  s_cnt_q, s_cnt_d;
  logic [2:0]  n_q, n_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic        fe_q, fe_d;
  logic        busy_q, busy_d;
  logic        done_ok, done_err;

  baud_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign rx = sync2_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      n_q       <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      fe_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      sync1_q   <= RxD;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_q       <= n_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      fe_q      <= fe_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    s_cnt_d  = s_cnt_q;
    n_d      = n_q;
    shreg_d  = shreg_q;
    done_ok  = 1'b0;
    done_err = 1'b0;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rx) begin
            state_d = START;
            s_cnt_d = '0;
          end
        end
        START: begin
          if (s_cnt_q == S_MID) begin
            s_cnt_d = '0;
            n_d     = '0;
            state_d = rx ? IDLE : DATA;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        DATA: begin
          if (s_cnt_q == S_LAST) begin
            shreg_d = {rx, shreg_q[7:1]};
            s_cnt_d = '0;
            if (n_q == N_LAST) state_d = STOP;
            else               n_d     = n_q + 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        STOP: begin
          if (s_cnt_q == S_LAST) begin
            state_d  = IDLE;
            done_ok  = rx;
            done_err = !rx;
          end else begin
            s_cnt_d = s_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // read clears first; a completion in the same cycle then overrides it
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q && !read;
    overrun_d = overrun_q && !read;
    fe_d      = fe_q && !read;
    busy_d    = (state_d != IDLE);
    if (done_ok) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
      if (valid_q && !read) overrun_d = 1'b1;
    end
    if (done_err) fe_d = 1'b1;
  end

  assign data        = data_q;
  assign valid       = valid_q;
  assign overrun     = overrun_q;
  assign frame_error = fe_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Frame-level bench for uart_rx: serial frames are built from bytes and the
// expected output register/flags come from a byte-level model of the rules.
module tb_uart_rx;

  localparam int unsigned CLK_DIV = 2;
  localparam int BIT_CYC   = 32;
  localparam int FRAME_CYC = 320;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RxD = 1'b1;
  logic       read = 1'b0;
  logic [7:0] data;
  logic       valid, overrun, frame_error, busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] m_data;
  logic       m_valid, m_ovr, m_fe;

  uart_rx #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .RxD         (RxD),
    .read        (read),
    .data        (data),
    .valid       (valid),
    .overrun     (overrun),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [11:0] obs();
    return {data, valid, overrun, frame_error, busy};
  endfunction

  // Byte-level model: read clears everything, then a frame outcome applies.
  task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic rd);
    logic prev_valid;
    prev_valid = m_valid;
    if (rd) begin
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_fe    = 1'b0;
    end
    if (stop_ok) begin
      if (prev_valid && !rd) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_data  = b;
    end else begin
      m_fe = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_read();
    @(negedge clk) read = 1'b1;
    @(negedge clk) read = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_fe    = 1'b0;
  endtask

  // Drives ncyc clocks of a frame; lat = first cycle valid is seen high.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int ncyc,
                            input int read_at, output int lat);
    logic [9:0] fr;
    fr  = {stop_bit, b, 1'b0};
    lat = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (lat < 0 && valid) lat = i;
      read = (i == read_at);
      RxD  = fr[i / BIT_CYC];
    end
    read = 1'b0;
    RxD  = 1'b1;
  endtask

  task automatic test_reset();
    logic [11:0] exp;
    reset = 1'b0;
    RxD   = 1'b1;
    read  = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    idle(3);
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL reset_state: got %h expected %h (data,valid,ovr,fe,busy)", obs(), exp);
    end
    reset = 1'b1;
    idle(4);
  endtask

  task automatic test_single();
    logic [11:0] exp;
    logic [7:0]  b;
    int lat;
    send_frame(8'h4D, 1'b1, FRAME_CYC, -1, lat);
    model_frame(8'h4D, 1'b1, 1'b0);
    idle(2);
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL single_4d: got %h expected %h", obs(), exp);
    end
    n_tests++;
    if (lat < 305 || lat > 310) begin
      n_fail++;
      $display("FAIL valid_latency: got %0d clocks expected 305..310", lat);
    end
    do_read();
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL single_read: got %h expected %h", obs(), exp);
    end
    for (int k = 0; k < 3; k++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1, FRAME_CYC, -1, lat);
      model_frame(b, 1'b1, 1'b0);
      idle(2);
      exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL single_rand[%0d]: got %h expected %h", k, obs(), exp);
      end
      do_read();
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] exp;
    int lat;
    send_frame(8'h4D, 1'b1, FRAME_CYC, -1, lat);
    model_frame(8'h4D, 1'b1, 1'b0);
    send_frame(8'hF0, 1'b1, FRAME_CYC, -1, lat);
    model_frame(8'hF0, 1'b1, 1'b0);
    idle(2);
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL b2b_overrun: got %h expected %h", obs(), exp);
    end
    do_read();
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL b2b_read: got %h expected %h", obs(), exp);
    end
  endtask

  task automatic test_frame_error();
    logic [11:0] exp;
    int lat;
    send_frame(8'h5A, 1'b1, FRAME_CYC, -1, lat);
    model_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'hA5, 1'b0, FRAME_CYC, -1, lat);
    model_frame(8'hA5, 1'b0, 1'b0);
    idle(40);
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL frame_error: got %h expected %h", obs(), exp);
    end
    do_read();
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL frame_error_read: got %h expected %h", obs(), exp);
    end
  endtask

  task automatic test_glitch();
    logic [11:0] exp;
    @(negedge clk) RxD = 1'b0;
    idle(3);
    @(negedge clk) RxD = 1'b1;
    idle(4);
    n_tests++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL glitch_busy: got %b expected 1", busy);
    end
    idle(40);
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL glitch_idle: got %h expected %h", obs(), exp);
    end
  endtask

  task automatic test_reset_midframe();
    logic [11:0] exp;
    int lat;
    send_frame(8'hC3, 1'b1, 170, -1, lat);
    reset = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0; m_fe = 1'b0;
    @(negedge clk);
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL midframe_reset: got %h expected %h", obs(), exp);
    end
    idle(2);
    reset = 1'b1;
    idle(200);
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h expected %h", obs(), exp);
    end
    send_frame(8'h3C, 1'b1, FRAME_CYC, -1, lat);
    model_frame(8'h3C, 1'b1, 1'b0);
    idle(2);
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL post_reset_3c: got %h expected %h", obs(), exp);
    end
    do_read();
  endtask

  // Frames of equal length keep the same tick phase, so the second frame
  // completes at the same offset measured on the first.
  task automatic test_read_collision();
    logic [11:0] exp;
    logic [7:0]  a, b;
    int lat, lat2;
    a = 8'($urandom);
    b = ~a;
    send_frame(a, 1'b1, FRAME_CYC, -1, lat);
    model_frame(a, 1'b1, 1'b0);
    send_frame(b, 1'b1, FRAME_CYC, lat - 1, lat2);
    model_frame(b, 1'b1, 1'b1);
    n_tests++;
    if (lat < 305 || lat > 310) begin
      n_fail++;
      $display("FAIL collision_latency: got %0d clocks expected 305..310", lat);
    end
    idle(2);
    exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
    n_tests++;
    if (obs() !== exp) begin
      n_fail++;
      $display("FAIL read_collision: got %h expected %h", obs(), exp);
    end
    do_read();
  endtask

  task automatic test_random();
    logic [11:0] exp;
    logic [7:0]  b;
    logic        stop_ok, rd;
    int lat;
    for (int k = 0; k < 10; k++) begin
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      rd      = 1'($urandom_range(0, 1));
      send_frame(b, stop_ok, FRAME_CYC, -1, lat);
      model_frame(b, stop_ok, 1'b0);
      idle(40 + int'($urandom_range(0, 7)));
      exp = {m_data, m_valid, m_ovr, m_fe, 1'b0};
      n_tests++;
      if (obs() !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] byte=%h stop=%b: got %h expected %h", k, b, stop_ok, obs(), exp);
      end
      if (rd) do_read();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    test_read_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
